spi_mcp4822_dac_writer: RTL and testbench

//  Downstream stage of the MCP3202 ADC reader. Takes each 12-bit sample (o_DATA/DATA_VALID of the ADC

---
 rtl/spi_mcp4822_dac_writer.sv | 156 +++++++++++++++
 tb/tb_spi_mcp4822_dac_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mcp4822_dac_writer.sv
// Writes 12-bit samples to an MCP4822 DAC over write-only SPI (mode 0,0, 16-bit frame, MSB first).
// Define SPI_DAC_LDAC_EN to add the o_LDAC_n output and its post-frame LDAC pulse.
module spi_mcp4822_dac_writer #(
    parameter bit CHANNEL  = 1'b0,
    parameter bit GAIN_1X  = 1'b1,
    parameter int SCK_HALF = 70
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] i_DATA,
    input  logic        i_DATA_VALID,
    output logic        MOSI,
    output logic        SCK,
    output logic        CS,
    output logic        o_BUSY,
    output logic        o_OVERRUN
`ifdef SPI_DAC_LDAC_EN
    ,
    output logic        o_LDAC_n
`endif
);

    localparam int              HC_W    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCK_HALF - 1);

    if (SCK_HALF < 1) begin : g_bad_sck_half
        $error("spi_mcp4822_dac_writer: SCK_HALF must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
`ifdef SPI_DAC_LDAC_EN
        ,
        LDAC
`endif
    } state_t;

    state_t          state;
    logic [HC_W-1:0] hc;
    logic [4:0]      bit_cnt;
    logic [14:0]     shreg;
    logic [11:0]     pending_data;
    logic            pending_full;
    logic            consume;
    logic            hc_done;
    logic [15:0]     frame_word;

    assign consume    = (state == IDLE) && pending_full;
    assign hc_done    = (hc == HC_LAST);
    assign frame_word = {CHANNEL, 1'b0, GAIN_1X, 1'b1, pending_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            hc           <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            pending_data <= '0;
            pending_full <= 1'b0;
            MOSI         <= 1'b0;
            SCK          <= 1'b0;
            CS           <= 1'b1;
            o_BUSY       <= 1'b0;
            o_OVERRUN    <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
            o_LDAC_n     <= 1'b1;
`endif
        end else begin
            o_OVERRUN <= 1'b0;

            // A strobe on the consuming edge refills the slot rather than overrunning it.
            if (i_DATA_VALID) begin
                pending_data <= i_DATA;
                pending_full <= 1'b1;
                if (pending_full && !consume)
                    o_OVERRUN <= 1'b1;
            end else if (consume) begin
                pending_full <= 1'b0;
            end

            if (state != IDLE)
                hc <= hc_done ? '0 : hc + 1'b1;

            case (state)
                IDLE: begin
                    hc <= '0;
                    if (pending_full) begin
                        CS      <= 1'b0;
                        MOSI    <= frame_word[15];
                        shreg   <= frame_word[14:0];
                        bit_cnt <= '0;
                        o_BUSY  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (hc_done) begin
                        SCK   <= 1'b1;
                        state <= SHIFT;
                    end
                end
                // Sixteen full SCK periods; the trailing low half of the last one
                // precedes HOLD, giving a CS-low window of 34 half-periods.
                SHIFT: begin
                    if (hc_done) begin
                        if (SCK) begin
                            SCK     <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt != 5'd15) begin
                                MOSI  <= shreg[14];
                                shreg <= {shreg[13:0], 1'b0};
                            end
                        end else if (bit_cnt == 5'd16) begin
                            state <= HOLD;
                        end else begin
                            SCK <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hc_done) begin
                        CS    <= 1'b1;
                        MOSI  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (hc_done) begin
`ifdef SPI_DAC_LDAC_EN
                        o_LDAC_n <= 1'b0;
                        state    <= LDAC;
`else
                        o_BUSY   <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
`ifdef SPI_DAC_LDAC_EN
                LDAC: begin
                    if (hc_done) begin
                        o_LDAC_n <= 1'b1;
                        o_BUSY   <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mcp4822_dac_writer.sv
// Scoreboard bench for spi_mcp4822_dac_writer: frames are decoded from SCK/MOSI and
// compared against expected words queued when each sample strobe is driven.
module tb_spi_mcp4822_dac_writer;

    localparam int H = 70;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dataA, dataB;
    logic        validA, validB;
    logic        mosiA, sckA, csA, busyA, overrunA;
    logic        mosiB, sckB, csB, busyB, overrunB;
`ifdef SPI_DAC_LDAC_EN
    logic        ldacA, ldacB;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] expQA[$];
    logic [15:0] expQB[$];

    always #4 clk = ~clk;

    spi_mcp4822_dac_writer #(.CHANNEL(1'b0), .GAIN_1X(1'b1), .SCK_HALF(H)) dutA (
        .clk(clk), .rst_n(rst_n), .i_DATA(dataA), .i_DATA_VALID(validA),
        .MOSI(mosiA), .SCK(sckA), .CS(csA), .o_BUSY(busyA), .o_OVERRUN(overrunA)
`ifdef SPI_DAC_LDAC_EN
        , .o_LDAC_n(ldacA)
`endif
    );

    spi_mcp4822_dac_writer #(.CHANNEL(1'b1), .GAIN_1X(1'b0), .SCK_HALF(H)) dutB (
        .clk(clk), .rst_n(rst_n), .i_DATA(dataB), .i_DATA_VALID(validB),
        .MOSI(mosiB), .SCK(sckB), .CS(csB), .o_BUSY(busyB), .o_OVERRUN(overrunB)
`ifdef SPI_DAC_LDAC_EN
        , .o_LDAC_n(ldacB)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] data, input logic expOvr, input logic replaceTail);
        dataA  = data;
        validA = 1'b1;
        if (replaceTail && expQA.size() > 0)
            void'(expQA.pop_back());
        expQA.push_back({4'h3, data});
        @(negedge clk);
        validA = 1'b0;
        checkOutput("overrun", {31'd0, overrunA}, {31'd0, expOvr});
    endtask

    task automatic waitDone();
        int n = 0;
        while ((expQA.size() != 0 || expQB.size() != 0 || busyA || busyB) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000)
            checkOutput("wait_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Frame decoder for dutA, sampled on the falling clk edge.
    logic        csPrevA = 1'b1, sckPrevA = 1'b0;
    logic        activeA = 1'b0, abortedA = 1'b0;
    logic [15:0] shiftA  = '0;
    int          risesA = 0, csLowA = 0, clkCnt = 0, lastRiseA = 0, periodBadA = 0;
    int          strayA = 0, ovrCount = 0;

    always @(negedge clk) begin
        clkCnt++;
        if (overrunA === 1'b1)
            ovrCount++;
        if (!rst_n && activeA)
            abortedA = 1'b1;
        if (csPrevA && !csA) begin
            activeA    = 1'b1;
            abortedA   = 1'b0;
            risesA     = 0;
            csLowA     = 1;
            periodBadA = 0;
        end else if (!csA) begin
            csLowA++;
        end
        if (sckA && !sckPrevA) begin
            if (csA) begin
                strayA++;
            end else begin
                shiftA = {shiftA[14:0], mosiA};
                if (risesA > 0 && (clkCnt - lastRiseA) != 2 * H)
                    periodBadA++;
                lastRiseA = clkCnt;
                risesA++;
            end
        end
        if (!csPrevA && csA && activeA) begin
            activeA = 1'b0;
            if (!abortedA) begin
                if (expQA.size() == 0)
                    checkOutput("unexpected_frame_a", {16'd0, shiftA}, 32'hFFFF_FFFF);
                else
                    checkOutput("frame_word_a", {16'd0, shiftA}, {16'd0, expQA.pop_front()});
                checkOutput("sck_rises_a", risesA, 16);
                checkOutput("cs_low_clks_a", csLowA, 34 * H);
                checkOutput("sck_period_errs_a", periodBadA, 0);
            end
        end
        csPrevA  = csA;
        sckPrevA = sckA;
    end

    logic        csPrevB = 1'b1, sckPrevB = 1'b0;
    logic [15:0] shiftB  = '0;
    int          risesB  = 0;

    always @(negedge clk) begin
        if (csPrevB && !csB)
            risesB = 0;
        if (sckB && !sckPrevB && !csB) begin
            shiftB = {shiftB[14:0], mosiB};
            risesB++;
        end
        if (!csPrevB && csB && rst_n) begin
            if (expQB.size() == 0)
                checkOutput("unexpected_frame_b", {16'd0, shiftB}, 32'hFFFF_FFFF);
            else
                checkOutput("frame_word_b", {16'd0, shiftB}, {16'd0, expQB.pop_front()});
            checkOutput("sck_rises_b", risesB, 16);
        end
        csPrevB  = csB;
        sckPrevB = sckB;
    end

    initial begin
        rst_n  = 1'b0;
        validA = 1'b0;
        validB = 1'b0;
        dataA  = '0;
        dataB  = '0;
        repeat (5) @(negedge clk);
        checkOutput("reset_cs", {31'd0, csA}, 1);
        checkOutput("reset_sck", {31'd0, sckA}, 0);
        checkOutput("reset_mosi", {31'd0, mosiA}, 0);
        checkOutput("reset_busy", {31'd0, busyA}, 0);
        checkOutput("reset_overrun", {31'd0, overrunA}, 0);
`ifdef SPI_DAC_LDAC_EN
        checkOutput("reset_ldac", {31'd0, ldacA}, 1);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Second instance: channel B, 2x gain.
        dataB  = 12'h003;
        validB = 1'b1;
        expQB.push_back(16'h9003);
        @(negedge clk);
        validB = 1'b0;

        applyStimulus(12'hD73, 1'b0, 1'b0);
        checkOutput("cs_before_latency", {31'd0, csA}, 1);
        @(negedge clk);
        checkOutput("cs_latency", {31'd0, csA}, 0);
        checkOutput("busy_in_frame", {31'd0, busyA}, 1);
        waitDone();

        // Overwrite of a pending sample mid-frame.
        applyStimulus(12'h123, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        applyStimulus(12'h456, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        applyStimulus(12'h789, 1'b1, 1'b1);
        waitDone();

        // Strobe landing on the very edge IDLE consumes the pending sample.
        applyStimulus(12'hAAA, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        applyStimulus(12'h555, 1'b0, 1'b0);
        begin
            int n = 0;
            while (busyA && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 5000)
                checkOutput("busy_fall_timeout", 1, 0);
        end
        applyStimulus(12'h666, 1'b0, 1'b0);
        waitDone();
        checkOutput("overrun_pulses", ovrCount, 1);

`ifdef SPI_DAC_LDAC_EN
        applyStimulus(12'hABC, 1'b0, 1'b0);
        begin
            int   n = 0;
            int   m = 0;
            logic busyPrev = 1'b0;
            while (!csA && n < 5000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("ldac_before_cs_rise", {31'd0, ldacA}, 1);
            n = 0;
            while (ldacA && n < 1000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("ldac_delay", n, H);
            while (!ldacA && m < 1000) begin
                busyPrev = busyA;
                @(negedge clk);
                m++;
            end
            checkOutput("ldac_width", m, H);
            checkOutput("busy_during_ldac", {31'd0, busyPrev}, 1);
            checkOutput("busy_at_ldac_rise", {31'd0, busyA}, 0);
        end
        waitDone();
`endif

        // Reset asserted mid-SHIFT aborts the frame; strobes during reset are dropped.
        dataA  = 12'h0F0;
        validA = 1'b1;
        @(negedge clk);
        validA = 1'b0;
        repeat (600) @(negedge clk);
        checkOutput("cs_mid_frame", {31'd0, csA}, 0);
        rst_n  = 1'b0;
        dataA  = 12'h321;
        validA = 1'b1;
        @(negedge clk);
        checkOutput("abort_cs", {31'd0, csA}, 1);
        checkOutput("abort_sck", {31'd0, sckA}, 0);
        checkOutput("abort_mosi", {31'd0, mosiA}, 0);
        checkOutput("abort_busy", {31'd0, busyA}, 0);
        repeat (9) @(negedge clk);
        validA = 1'b0;
        rst_n  = 1'b1;
        repeat (400) @(negedge clk);
        checkOutput("stray_sck_rises", strayA, 0);
        checkOutput("idle_after_reset_cs", {31'd0, csA}, 1);
        checkOutput("idle_after_reset_busy", {31'd0, busyA}, 0);
        checkOutput("queue_a_empty", expQA.size(), 0);
        checkOutput("queue_b_empty", expQB.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
